// File: rtl/comm_buffer_arbiter.sv
// comm_buffer_arbiter: round-robin arbiter with atomic lock sharing one buffer port between requesters A and B
module comm_buffer_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              buf_we,
  output logic              buf_re,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t state, stateNext;
  logic lockHeld, lockB, lastB, capWe, capLock, capB;
  logic [1:0] latCnt;
  logic aAct, bAct, pickB, issueNow, rdDone, lockNext, busyNext;
  logic selWe, selLock;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  // Arbitration (a held lock masks the other side) and next-state selection
  always_comb begin
    aAct = a_req && !(lockHeld && lockB);
    bAct = b_req && !(lockHeld && !lockB);
    pickB = bAct && (!aAct || !lastB);
    issueNow = (state == IDLE) && (aAct || bAct);
    rdDone = latCnt == 2'(READ_LAT - 1);
    selWe = pickB ? b_we : a_we;
    selLock = pickB ? b_lock : a_lock;
    selAddr = pickB ? b_addr : a_addr;
    selWdata = pickB ? b_wdata : a_wdata;
    stateNext = state;
    case (state)
      IDLE:    stateNext = issueNow ? ISSUE : IDLE;
      ISSUE:   stateNext = capWe ? IDLE : RD_WAIT;
      RD_WAIT: stateNext = rdDone ? IDLE : RD_WAIT;
      default: stateNext = IDLE;
    endcase
    lockNext = (state == ISSUE) ? capLock : lockHeld;
    busyNext = (stateNext != IDLE) || lockNext;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= stateNext;
  end
  // Registered outputs, captured access, lock and round-robin bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      buf_addr <= '0;
      buf_wdata <= '0;
      buf_we <= 1'b0;
      buf_re <= 1'b0;
      busy <= 1'b0;
      lockHeld <= 1'b0;
      lockB <= 1'b0;
      lastB <= 1'b1;
      capWe <= 1'b0;
      capLock <= 1'b0;
      capB <= 1'b0;
      latCnt <= '0;
    end else begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      buf_we <= 1'b0;
      buf_re <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      busy <= busyNext;
      if (issueNow) begin
        capB <= pickB;
        lastB <= pickB;
        capWe <= selWe;
        capLock <= selLock;
        a_gnt <= !pickB;
        b_gnt <= pickB;
        buf_we <= selWe;
        buf_re <= !selWe;
        buf_addr <= selAddr;
        buf_wdata <= selWdata;
      end
      if (state == ISSUE) begin
        lockHeld <= capLock;
        lockB <= capB;
        latCnt <= '0;
      end
      if (state == RD_WAIT) begin
        latCnt <= latCnt + 2'd1;
        if (rdDone && capB) begin
          b_rvalid <= 1'b1;
          b_rdata <= buf_rdata;
        end
        if (rdDone && !capB) begin
          a_rvalid <= 1'b1;
          a_rdata <= buf_rdata;
        end
      end
    end
  end
endmodule

// File: doc/comm_buffer_arbiter.md
Name: comm_buffer_arbiter

Overview:
- Shares the single-port 256 x 4-bit communication buffer between two requesters: A (parallel host side) and B (FPGA-internal side).
- Serialises their read/write accesses with round-robin fairness and an optional lock for atomic read-modify-write sequences.
- Drives the buffer's address, write-data and strobe inputs, and routes the buffer's read data back to whichever requester issued the read.
- Fully synchronous; sits between both requesters and the buffer storage.

Parameters:
- ADDR_W, 8: buffer address width (2**ADDR_W entries).
- DATA_W, 4: buffer data width.
- READ_LAT, 1: cycles from buf_re asserted to buf_rdata valid; legal range 1..3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  requester A access request; level, held until a_gnt.
- a_we  input  1  A: 1 = write, 0 = read; stable while a_req is high.
- a_lock  input  1  A: keep ownership after this access.
- a_addr  input  ADDR_W  A access address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  one-cycle pulse: A's access is issued this cycle.
- a_rvalid  output  1  one-cycle pulse: a_rdata is valid.
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical set for requester B.
- buf_addr  output  ADDR_W  buffer address.
- buf_wdata  output  DATA_W  buffer write data.
- buf_we  output  1  buffer write strobe, one cycle.
- buf_re  output  1  buffer read strobe, one cycle.
- buf_rdata  input  DATA_W  buffer read data, valid READ_LAT cycles after buf_re.
- busy  output  1  high when state != IDLE or a lock is held.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 and the state goes to IDLE.
  - Ownership lock is cleared; last_winner is set to B, so A wins the first tie.
  - A read in flight is discarded: no rvalid is produced for it.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Samples the requests; the winner's we/addr/wdata/lock are captured, and the state moves to ISSUE.
  - No request: stay in IDLE.
- Arbitration:
  - Lock held by X: only X's request is considered; the other requester waits, whatever it requests.
  - Otherwise, if one requester is active, it wins.
  - If both are active, the requester other than last_winner wins; last_winner is then updated.
- ISSUE (exactly one cycle):
  - x_gnt = 1; buf_addr/buf_wdata driven from the captured values.
  - Write: buf_we = 1, next state IDLE.
  - Read: buf_re = 1, next state RD_WAIT.
  - Lock: set if the captured lock = 1, cleared if 0.
- RD_WAIT:
  - Counts READ_LAT cycles after ISSUE and registers buf_rdata in the last of them.
  - In the following cycle, x_rvalid = 1 and x_rdata = data, for one cycle only; the state returns to IDLE in that same cycle.
  - x_rdata holds its value until the next read for the same requester.
- Timing, with a request first sampled in cycle t:
  - gnt and strobe appear in cycle t+1.
  - Write: the next request is sampled in t+2.
  - Read: rvalid appears in t+2+READ_LAT; the next request is sampled in that cycle.
- Requester contract:
  - Drop req, or present a new access, in the cycle after gnt.
  - req still high when IDLE samples it is a new access.
- buf_addr and buf_wdata hold their last values when no strobe is active.
- Strobes: never both buf_we and buf_re together; at most one gnt per cycle.
- Lock released while the other requester is waiting: the waiting requester wins the next IDLE arbitration.
- Lock held with the owner's req low: the arbiter stays in IDLE and busy = 1; the other requester starves until the owner issues an access with lock = 0.
- Address wrap: full ADDR_W range, no checking; address 255 is legal.

Test Plan:
- After reset, A writes 0xA to addr 0x10, then reads addr 0x10. Required: a_gnt and buf_we one cycle after req, with buf_addr = 0x10 and buf_wdata = 0xA. The read then produces buf_re, and a_rvalid with a_rdata = 0xA in cycle t+3 (READ_LAT = 1).
- A and B both request writes continuously for 6 accesses. Required: grants alternate A, B, A, B, A, B; A is granted first after reset; never two strobes or two gnts in one cycle.
- A reads addr 0x05 with lock = 1, then writes 0x3 to 0x05 with lock = 0, while B requests throughout. Required: B's gnt only after A's unlocked write completes; busy stays 1 throughout.
- READ_LAT = 3 and B reads addr 0xFF (preloaded 0x7). Required: b_rvalid arrives 4 cycles after b_gnt with b_rdata = 0x7; a_rvalid stays 0.
- rst asserted during RD_WAIT. Required: all outputs 0 the next cycle, no rvalid ever produced for the aborted read, and A wins the first tie after reset.
